// File: rtl/t08_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory request/ack channel plus the
// decoder-facing instruction buffer head.
interface t08_fetch_unit_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  // Handshakes: mem_req/mem_addr stay stable until a cycle with mem_ack=1, which
  // completes the transfer (mem_rdata valid that cycle, same-cycle ack allowed);
  // the buffer head transfers on any edge where instr_valid && instr_ready.
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  logic              instr_valid;
  logic              instr_ready;
  logic [DATA_W-1:0] instr;
  logic [ADDR_W-1:0] program_counter;

  modport master (
    output mem_req, mem_addr, instr_valid, instr, program_counter,
    input  mem_ack, mem_rdata, instr_ready
  );

  modport slave (
    input  mem_req, mem_addr, instr_valid, instr, program_counter,
    output mem_ack, mem_rdata, instr_ready
  );
endinterface

// File: rtl/t08_fetch_unit.sv
// Fetch stage: PC generation with branch/jump/jalr redirects, single-outstanding
// memory request, and a small instruction FIFO feeding the decoder.
module t08_fetch_unit #(
  parameter int unsigned       ADDR_W     = 32,
  parameter int unsigned       DATA_W     = 32,
  parameter int unsigned       PC_STEP    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter int unsigned       IBUF_DEPTH = 2
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              branch,
  input  logic              jump,
  input  logic              jalr,
  input  logic [ADDR_W-1:0] redir_pc,
  input  logic [ADDR_W-1:0] imm_address,
  input  logic [ADDR_W-1:0] rs1_value,
  output logic [ADDR_W-1:0] ret_address,
  output logic [ADDR_W-1:0] fetch_pc,
  output logic [1:0]        dbg_state,
  t08_fetch_unit_if.master  bus
);
  localparam int unsigned PTR_W = $clog2(IBUF_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_FULL  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] drain_addr_q, drain_addr_d;
  logic [ADDR_W-1:0] ret_q, ret_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [DATA_W-1:0] data_q [IBUF_DEPTH];
  logic [DATA_W-1:0] data_d [IBUF_DEPTH];
  logic [ADDR_W-1:0] pc_q   [IBUF_DEPTH];
  logic [ADDR_W-1:0] pc_d   [IBUF_DEPTH];

  logic              redirect;
  logic [ADDR_W-1:0] target;
  logic              buf_full;
  logic              pop;
  logic              push;

  assign redirect = branch | jump | jalr;
  assign target   = jalr ? ((rs1_value + imm_address) & ~ADDR_W'(1))
                         : (redir_pc + imm_address);
  assign buf_full = (count_q == CNT_W'(IBUF_DEPTH));

  assign bus.instr_valid     = (count_q != '0);
  assign bus.instr           = data_q[rd_ptr_q];
  assign bus.program_counter = pc_q[rd_ptr_q];
  assign bus.mem_req         = ((state_q == ST_FETCH) && !buf_full) || (state_q == ST_DRAIN);
  // While draining, the old address must stay on the bus even though fetch_pc moved on.
  assign bus.mem_addr        = (state_q == ST_DRAIN) ? drain_addr_q : fetch_pc_q;

  assign pop         = bus.instr_valid && bus.instr_ready;
  assign push        = (state_q == ST_FETCH) && bus.mem_req && bus.mem_ack && !redirect;
  assign ret_address = ret_q;
  assign fetch_pc    = fetch_pc_q;
  assign dbg_state   = state_q;

  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    drain_addr_d = drain_addr_q;
    ret_d        = ret_q;
    data_d       = data_q;
    pc_d         = pc_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    count_d      = count_q;

    if (redirect) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        data_d[wr_ptr_q] = bus.mem_rdata;
        pc_d[wr_ptr_q]   = bus.mem_addr;
        wr_ptr_d         = wr_ptr_q + PTR_W'(1);
      end
      rd_ptr_d = rd_ptr_q + PTR_W'(pop);
      count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    case (state_q)
      ST_IDLE:  state_d = ST_FETCH;
      ST_FETCH: begin
        if (buf_full) begin
          state_d = ST_FULL;
        end else if (push) begin
          fetch_pc_d = fetch_pc_q + ADDR_W'(PC_STEP);
          if (count_d == CNT_W'(IBUF_DEPTH)) state_d = ST_FULL;
        end
      end
      ST_FULL:  if (pop) state_d = ST_FETCH;
      ST_DRAIN: if (bus.mem_ack) state_d = ST_FETCH;
      default:  state_d = ST_IDLE;
    endcase

    // An unacked outstanding request must still complete, so its response is drained.
    if (redirect) begin
      fetch_pc_d   = target;
      drain_addr_d = bus.mem_addr;
      state_d      = (bus.mem_req && !bus.mem_ack) ? ST_DRAIN : ST_FETCH;
      if (jump || jalr) ret_d = redir_pc + ADDR_W'(PC_STEP);
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q      <= ST_IDLE;
      fetch_pc_q   <= RESET_PC;
      drain_addr_q <= '0;
      ret_q        <= '0;
      count_q      <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      drain_addr_q <= drain_addr_d;
      ret_q        <= ret_d;
      count_q      <= count_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    data_q <= data_d;
    pc_q   <= pc_d;
  end
endmodule

// File: tb/tb_t08_fetch_unit.sv
// Directed bench for t08_fetch_unit: a per-cycle vector table plus a
// hand-written fill / redirect-with-pop sequence.
module tb_t08_fetch_unit;
  logic        clk;
  logic        nrst;
  logic        branch, jump, jalr;
  logic [31:0] redir_pc, imm_address, rs1_value;
  logic [31:0] ret_address, fetch_pc;
  logic [1:0]  dbg_state;

  int checks   = 0;
  int failures = 0;

  t08_fetch_unit_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  t08_fetch_unit #(
    .ADDR_W(32), .DATA_W(32), .PC_STEP(4), .RESET_PC(32'h0), .IBUF_DEPTH(2)
  ) dut (
    .clk(clk), .nrst(nrst), .branch(branch), .jump(jump), .jalr(jalr),
    .redir_pc(redir_pc), .imm_address(imm_address), .rs1_value(rs1_value),
    .ret_address(ret_address), .fetch_pc(fetch_pc), .dbg_state(dbg_state),
    .bus(bus.master)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        nrst, br, jp, jr;
    logic [31:0] redir, imm, rs1;
    logic        ack;
    logic [31:0] rdata;
    logic        ready;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_instr, e_pc, e_fetch, e_ret;
  } vec_t;

  localparam int NV = 21;
  vec_t tbl [NV];

  function automatic vec_t mk(
    input logic n, input logic b, input logic j, input logic r,
    input logic [31:0] rp, input logic [31:0] im, input logic [31:0] rs,
    input logic a, input logic [31:0] rd, input logic rdy,
    input logic er, input logic [31:0] ea, input logic ev,
    input logic [31:0] ei, input logic [31:0] ep, input logic [31:0] ef,
    input logic [31:0] ert);
    vec_t v;
    v.nrst = n; v.br = b; v.jp = j; v.jr = r;
    v.redir = rp; v.imm = im; v.rs1 = rs;
    v.ack = a; v.rdata = rd; v.ready = rdy;
    v.e_req = er; v.e_addr = ea; v.e_valid = ev;
    v.e_instr = ei; v.e_pc = ep; v.e_fetch = ef; v.e_ret = ert;
    return v;
  endfunction

  // scoreboard compare
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    nrst            = v.nrst;
    branch          = v.br;
    jump            = v.jp;
    jalr            = v.jr;
    redir_pc        = v.redir;
    imm_address     = v.imm;
    rs1_value       = v.rs1;
    bus.mem_ack     = v.ack;
    bus.mem_rdata   = v.rdata;
    bus.instr_ready = v.ready;
  endtask

  task automatic idle_inputs();
    branch = 1'b0; jump = 1'b0; jalr = 1'b0;
    redir_pc = '0; imm_address = '0; rs1_value = '0;
  endtask

  initial begin
    int acks;
    bit saw_req;
    bit done;

    tbl[0]  = mk(1,0,0,0, 0,0,0,                     1,32'h0,1,         0,0,0,0,0,0,0);
    tbl[1]  = mk(1,0,0,0, 0,0,0,                     1,32'h1000_0000,1, 1,0,0,0,0,0,0);
    tbl[2]  = mk(1,0,0,0, 0,0,0,                     1,32'h1000_0004,1, 1,4,1,32'h1000_0000,0,4,0);
    tbl[3]  = mk(1,0,0,0, 0,0,0,                     1,32'h1000_0008,1, 1,8,1,32'h1000_0004,4,8,0);
    tbl[4]  = mk(1,0,0,0, 0,0,0,                     1,32'h1000_000C,1, 1,12,1,32'h1000_0008,8,12,0);
    tbl[5]  = mk(1,1,0,0, 8,16,0,                    1,32'h1000_0010,1, 1,16,1,32'h1000_000C,12,16,0);
    tbl[6]  = mk(1,0,1,0, 32'h20,32'hFFFF_FFF6,0,    1,32'h0,1,         1,24,0,0,0,24,0);
    tbl[7]  = mk(1,0,1,1, 32'h40,4,32'h101,          1,32'h0,1,         1,32'h16,0,0,0,32'h16,32'h24);
    tbl[8]  = mk(1,0,0,0, 0,0,0,                     1,32'h2000_0104,0, 1,32'h104,0,0,0,32'h104,32'h44);
    tbl[9]  = mk(1,0,0,0, 0,0,0,                     1,32'h2000_0108,0, 1,32'h108,1,32'h2000_0104,32'h104,32'h108,32'h44);
    tbl[10] = mk(1,0,0,0, 0,0,0,                     1,32'h0,0,         0,0,1,32'h2000_0104,32'h104,32'h10C,32'h44);
    tbl[11] = mk(1,0,0,0, 0,0,0,                     1,32'h0,1,         0,0,1,32'h2000_0104,32'h104,32'h10C,32'h44);
    tbl[12] = mk(1,0,1,0, 32'h200,32'h40,0,          0,32'h0,0,         1,32'h10C,1,32'h2000_0108,32'h108,32'h10C,32'h44);
    tbl[13] = mk(1,0,0,0, 0,0,0,                     0,32'h0,0,         1,32'h10C,0,0,0,32'h240,32'h204);
    tbl[14] = mk(1,0,0,0, 0,0,0,                     0,32'h0,0,         1,32'h10C,0,0,0,32'h240,32'h204);
    tbl[15] = mk(1,0,0,0, 0,0,0,                     1,32'hDEAD_BEEF,0, 1,32'h10C,0,0,0,32'h240,32'h204);
    tbl[16] = mk(1,0,0,0, 0,0,0,                     1,32'h3000_0240,1, 1,32'h240,0,0,0,32'h240,32'h204);
    tbl[17] = mk(0,0,0,0, 0,0,0,                     1,32'h5555_5555,1, 1,32'h244,1,32'h3000_0240,32'h240,32'h244,32'h204);
    tbl[18] = mk(1,0,0,0, 0,0,0,                     1,32'h0,0,         0,0,0,0,0,0,0);
    tbl[19] = mk(1,0,0,0, 0,0,0,                     1,32'h1000_0000,0, 1,0,0,0,0,0,0);
    tbl[20] = mk(1,0,0,0, 0,0,0,                     0,32'h0,0,         1,4,1,32'h1000_0000,0,4,0);

    nrst = 1'b0;
    idle_inputs();
    bus.mem_ack = 1'b0; bus.mem_rdata = '0; bus.instr_ready = 1'b0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(tbl[i]);
      #1;
      check($sformatf("v%0d mem_req", i), {31'b0, bus.mem_req}, {31'b0, tbl[i].e_req});
      if (tbl[i].e_req) check($sformatf("v%0d mem_addr", i), bus.mem_addr, tbl[i].e_addr);
      check($sformatf("v%0d instr_valid", i), {31'b0, bus.instr_valid}, {31'b0, tbl[i].e_valid});
      if (tbl[i].e_valid) begin
        check($sformatf("v%0d instr", i), bus.instr, tbl[i].e_instr);
        check($sformatf("v%0d program_counter", i), bus.program_counter, tbl[i].e_pc);
      end
      check($sformatf("v%0d fetch_pc", i), fetch_pc, tbl[i].e_fetch);
      check($sformatf("v%0d ret_address", i), ret_address, tbl[i].e_ret);
    end

    // Fill with decoder stalled: exactly two acks land, then request drops.
    @(negedge clk);
    nrst = 1'b0; idle_inputs();
    bus.mem_ack = 1'b1; bus.instr_ready = 1'b0; bus.mem_rdata = '0;
    @(posedge clk);
    @(negedge clk);
    nrst = 1'b1;
    acks = 0; saw_req = 1'b0; done = 1'b0;
    for (int c = 0; c < 10 && !done; c++) begin
      bus.mem_rdata = 32'h4000_0000 | bus.mem_addr;
      #1;
      if (bus.mem_req) begin
        acks++;
        saw_req = 1'b1;
      end else if (saw_req) begin
        done = 1'b1;
      end
      if (!done) begin
        @(posedge clk);
        @(negedge clk);
      end
    end
    check("fill budget", {31'b0, done}, 32'd1);
    check("fill ack count", acks, 32'd2);
    check("fill fetch_pc", fetch_pc, 32'h8);
    check("fill head instr", bus.instr, 32'h4000_0000);
    check("fill state full", {30'b0, dbg_state}, 32'd2);

    // Redirect coincident with a pop: flush wins, fetch restarts at target.
    branch = 1'b1; redir_pc = 32'h1000; imm_address = 32'h20;
    bus.instr_ready = 1'b1; bus.mem_ack = 1'b0;
    @(posedge clk);
    @(negedge clk);
    idle_inputs();
    #1;
    check("flush instr_valid", {31'b0, bus.instr_valid}, 32'd0);
    check("flush mem_req", {31'b0, bus.mem_req}, 32'd1);
    check("flush mem_addr", bus.mem_addr, 32'h1020);
    check("flush ret_address", ret_address, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/t08_fetch_unit.md
Name: t08_fetch_unit

Overview:
Parametrised next-generation fetch stage. It combines the PC generator (sequential, branch, jump, and new register-indirect jalr redirects) with a single-outstanding memory request/acknowledge handshake and a small instruction buffer that decouples fetch from decode. It sits between the instruction memory port and the decoder, and receives redirects from execute.

Parameters:
ADDR_W, 32, width of all addresses, immediates and PCs
DATA_W, 32, instruction word width
PC_STEP, 4, sequential PC increment and return-address offset
RESET_PC, 0, fetch address after reset
IBUF_DEPTH, 2, instruction buffer entries (power of two, >=2)

Ports:
clk  in  1  system clock
nrst  in  1  synchronous active-low reset
branch  in  1  taken branch, target = redir_pc + imm_address
jump  in  1  jal, target = redir_pc + imm_address, writes ret_address
jalr  in  1  jalr, target = (rs1_value + imm_address) & ~1, writes ret_address
redir_pc  in  ADDR_W  PC of the redirecting instruction
imm_address  in  ADDR_W  signed immediate offset
rs1_value  in  ADDR_W  jalr base register
ret_address  out  ADDR_W  redir_pc + PC_STEP, captured on jump/jalr
mem_req  out  1  instruction read request
mem_addr  out  ADDR_W  request address
mem_ack  in  1  response valid; mem_rdata valid this cycle
mem_rdata  in  DATA_W  fetched instruction
instr_valid  out  1  buffer head valid
instr_ready  in  1  decoder accepts head
instr  out  DATA_W  head instruction
program_counter  out  ADDR_W  PC of head instruction
fetch_pc  out  ADDR_W  next address to request

Behaviour:
- Clock is clk; reset is synchronous, active-low, named nrst. All state updates on posedge clk.
- Reset (nrst=0 at an edge, including mid-request):
  - fetch_pc=RESET_PC; buffer empty; instr_valid=0; mem_req=0; ret_address=0; state=IDLE.
  - A pending ack is ignored.
- Redirect priority: jalr > jump > branch. Address arithmetic is two's-complement modulo 2^ADDR_W with no overflow flag.
- States:
  - IDLE: mem_req=0. Moves to FETCH the cycle after reset is released.
  - FETCH:
    - Request is issued only if the buffer has at least one free slot; otherwise go to FULL.
    - mem_req=1, mem_addr=fetch_pc. mem_req and mem_addr are held stable until mem_ack.
    - A same-cycle ack is legal.
    - On ack: push {mem_rdata, mem_addr}; fetch_pc += PC_STEP. Stay in FETCH, or go to FULL if the buffer is now full.
  - FULL: mem_req=0. Return to FETCH in the cycle after a pop frees a slot.
  - DRAIN:
    - Entered when a redirect arrives while a request is outstanding without an ack that cycle.
    - mem_req stays 1 with the old address until ack. The acked data is discarded, then go to FETCH.
- Redirect in any state:
  - The buffer is flushed in the same edge, so instr_valid=0 next cycle.
  - fetch_pc=target.
  - ret_address updated on jump/jalr only, and holds otherwise.
  - A redirect coincident with mem_ack discards that response and goes straight to FETCH.
  - A redirect coincident with a pop: the flush wins.
- Buffer:
  - FIFO of IBUF_DEPTH entries with wrapping read/write pointers and a count.
  - Simultaneous push and pop on a full buffer is legal; the count is unchanged.
  - instr and program_counter show the head entry.
  - Pop occurs when instr_valid && instr_ready.
  - Fill-to-use latency: ack at edge N gives instr_valid=1 after edge N.
- Unacked requests have no timeout.

Test Plan:
- Reset then mem_ack tied 1, instr_ready=1 -> mem_addr 0,4,8,12 on consecutive cycles; program_counter trails by one cycle; instr matches mem_rdata.
- branch=1, redir_pc=8, imm_address=16 -> buffer flushed, next mem_addr=24, ret_address unchanged (0).
- jump=1, redir_pc=0x20, imm_address=-10 -> next mem_addr=0x16, ret_address=0x24. Then jalr=1 with jump=1, rs1_value=0x101, imm_address=4 -> jalr wins, mem_addr=0x104, ret_address=redir_pc+4.
- instr_ready=0 with IBUF_DEPTH=2 -> exactly two acks accepted, mem_req drops to 0. One pop -> mem_req reasserts next cycle at the next sequential address.
- mem_ack delayed 3 cycles, jump issued in the first wait cycle -> mem_addr held at old value until ack, data discarded (instr_valid stays 0), then request at the jump target.
- nrst=0 for one edge while mem_req=1 -> next cycle mem_req=0, instr_valid=0, fetch_pc=RESET_PC; fetching restarts from RESET_PC.
